// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one external combinational ALU between two requesters using
//   round-robin arbitration. An accepted request is latched into the ALU
//   operand registers. One cycle later the ALU result and flags are
//   captured. They are then returned to the granted requester through a
//   valid/ready handshake.
//
// Ports:
//   clk, rst              clock; synchronous active-low reset
//   req_valid/req_ready   per-requester request handshake (bit i = requester i)
//   req_a/req_b/req_sel   packed operands, requester i in slice i
//   alu_a/alu_b/alu_sel   registered ALU operands
//   alu_result/alu_flags  ALU outputs, flags = {carry, negative, zero}
//   rsp_valid/rsp_ready   per-requester response handshake
//   rsp_result/rsp_flags  captured result and flags of the current response
//   disp_result/disp_flags last completed result and flags, for displays
//   busy                  high whenever the controller is not idle
//   op_count              completed operations, saturating
module alu_share_arbiter #(
    parameter int WIDTH = 4,
    parameter int SEL_W = 3,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    input  logic [2*SEL_W-1:0]   req_sel,
    output logic [1:0]           req_ready,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [SEL_W-1:0]     alu_sel,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic [2:0]           alu_flags,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [WIDTH-1:0]     rsp_result,
    output logic [2:0]           rsp_flags,
    output logic [WIDTH-1:0]     disp_result,
    output logic [2:0]           disp_flags,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_e;

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic [SEL_W-1:0]   alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic [2:0]         rsp_flags_q, rsp_flags_d;
    logic [WIDTH-1:0]   disp_result_q, disp_result_d;
    logic [2:0]         disp_flags_q, disp_flags_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;

    logic               gnt;
    logic               accept;

    always_comb begin
        // On a tie the requester not served last wins. Otherwise the only
        // valid requester wins. With no request gnt is 0 and accept stays low.
        gnt    = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
        accept = (state_q == ST_IDLE) && req_valid[gnt];

        state_d       = state_q;
        last_grant_d  = last_grant_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_sel_d     = alu_sel_q;
        rsp_result_d  = rsp_result_q;
        rsp_flags_d   = rsp_flags_q;
        disp_result_d = disp_result_q;
        disp_flags_d  = disp_flags_q;
        op_count_d    = op_count_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    alu_a_d      = gnt ? req_a[2*WIDTH-1:WIDTH]   : req_a[WIDTH-1:0];
                    alu_b_d      = gnt ? req_b[2*WIDTH-1:WIDTH]   : req_b[WIDTH-1:0];
                    alu_sel_d    = gnt ? req_sel[2*SEL_W-1:SEL_W] : req_sel[SEL_W-1:0];
                    last_grant_d = gnt;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_result_d  = alu_result;
                rsp_flags_d   = alu_flags;
                disp_result_d = alu_result;
                disp_flags_d  = alu_flags;
                state_d       = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready[last_grant_q]) begin
                    if (op_count_q != '1) begin
                        op_count_d = op_count_q + CNT_W'(1);
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= 1'b1;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_sel_q     <= '0;
            rsp_result_q  <= '0;
            rsp_flags_q   <= '0;
            disp_result_q <= '0;
            disp_flags_q  <= '0;
            op_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_sel_q     <= alu_sel_d;
            rsp_result_q  <= rsp_result_d;
            rsp_flags_q   <= rsp_flags_d;
            disp_result_q <= disp_result_d;
            disp_flags_q  <= disp_flags_d;
            op_count_q    <= op_count_d;
        end
    end

    assign req_ready   = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid   = (state_q == ST_RESP) ? (last_grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign busy        = (state_q != ST_IDLE);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_sel     = alu_sel_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_flags   = rsp_flags_q;
    assign disp_result = disp_result_q;
    assign disp_flags  = disp_flags_q;
    assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Directed and randomized bench for alu_share_arbiter. It uses a
//   behavioural ALU stub and a transaction-level reference model. A second
//   instance with CNT_W=2 shares all inputs to exercise counter saturation.
module tb_alu_share_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid, rsp_ready;
    logic [7:0] req_a, req_b;
    logic [5:0] req_sel;

    logic [1:0] req_ready, rsp_valid;
    logic [3:0] alu_a, alu_b, alu_result, rsp_result, disp_result;
    logic [2:0] alu_sel, alu_flags, rsp_flags, disp_flags;
    logic       busy;
    logic [7:0] op_count;

    logic [1:0] req_ready_s, rsp_valid_s;
    logic [3:0] alu_a_s, alu_b_s, alu_result_s, rsp_result_s, disp_result_s;
    logic [2:0] alu_sel_s, alu_flags_s, rsp_flags_s, disp_flags_s;
    logic       busy_s;
    logic [1:0] op_count_s;

    logic       use_fixed = 1'b0;
    logic [3:0] fixed_res = '0;
    logic [2:0] fixed_flg = '0;

    int compared = 0;
    int mismatched = 0;

    // Reference model state
    int         m_last;
    int         m_count;
    logic [3:0] m_dres, m_a, m_b;
    logic [2:0] m_dflg, m_s;

    always #5 clk = ~clk;

    // Behavioural ALU: returns {carry, negative, zero, result}
    function automatic logic [6:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] s);
        logic [4:0] w;
        case (s)
            3'd0: w = {1'b0, a & b};
            3'd1: w = {1'b0, a | b};
            3'd2: w = {1'b0, a} + {1'b0, b};
            3'd3: w = {1'b0, a} - {1'b0, b};
            3'd4: w = {1'b0, a ^ b};
            3'd5: w = {1'b0, ~a};
            3'd6: w = {1'b0, a};
            default: w = {1'b0, b};
        endcase
        return {w[4], w[3], (w[3:0] == 4'd0), w[3:0]};
    endfunction

    assign {alu_flags, alu_result}     = use_fixed ? {fixed_flg, fixed_res} : alu_ref(alu_a, alu_b, alu_sel);
    assign {alu_flags_s, alu_result_s} = use_fixed ? {fixed_flg, fixed_res} : alu_ref(alu_a_s, alu_b_s, alu_sel_s);

    alu_share_arbiter #(.WIDTH(4), .SEL_W(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_sel(req_sel), .req_ready(req_ready), .alu_a(alu_a), .alu_b(alu_b),
        .alu_sel(alu_sel), .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .disp_result(disp_result), .disp_flags(disp_flags),
        .busy(busy), .op_count(op_count)
    );

    alu_share_arbiter #(.WIDTH(4), .SEL_W(3), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_sel(req_sel), .req_ready(req_ready_s), .alu_a(alu_a_s), .alu_b(alu_b_s),
        .alu_sel(alu_sel_s), .alu_result(alu_result_s), .alu_flags(alu_flags_s),
        .rsp_valid(rsp_valid_s), .rsp_ready(rsp_ready), .rsp_result(rsp_result_s),
        .rsp_flags(rsp_flags_s), .disp_result(disp_result_s), .disp_flags(disp_flags_s),
        .busy(busy_s), .op_count(op_count_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply reset for one edge and check every output is cleared
    task automatic do_reset();
        rst       = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        @(posedge clk); #1;
        rst = 1'b1;
        m_last = 1; m_count = 0;
        m_dres = '0; m_dflg = '0; m_a = '0; m_b = '0; m_s = '0;
        #1;
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_sel", alu_sel, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_rsp_flags", rsp_flags, 0);
        chk("rst_disp_result", disp_result, 0);
        chk("rst_disp_flags", disp_flags, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_op_count_sat", op_count_s, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
    endtask

    // One full transaction starting in an idle cycle. bp = response stall
    // cycles; abort = reset during the response phase instead of completing.
    task automatic run_op(input logic [1:0] vm,
                          input logic [3:0] a0, input logic [3:0] b0, input logic [2:0] s0,
                          input logic [3:0] a1, input logic [3:0] b1, input logic [2:0] s1,
                          input int bp, input bit abort);
        int         g;
        logic [1:0] oh;
        logic [3:0] ea, eb;
        logic [2:0] es;
        logic [6:0] r;
        req_valid = vm;
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        req_sel   = {s1, s0};
        rsp_ready = 2'b00;
        g  = (vm == 2'b11) ? 1 - m_last : ((vm == 2'b10) ? 1 : 0);
        oh = (g == 1) ? 2'b10 : 2'b01;
        ea = (g == 1) ? a1 : a0;
        eb = (g == 1) ? b1 : b0;
        es = (g == 1) ? s1 : s0;
        r  = use_fixed ? {fixed_flg, fixed_res} : alu_ref(ea, eb, es);
        #1;
        chk("idle_req_ready", req_ready, oh);
        chk("idle_busy", busy, 0);
        chk("idle_rsp_valid", rsp_valid, 0);

        @(posedge clk); #1;
        m_last = g; m_a = ea; m_b = eb; m_s = es;
        // Requests seen outside idle must not disturb the ALU operands
        req_valid = vm & ~oh;
        req_a     = 8'($urandom());
        req_b     = 8'($urandom());
        req_sel   = 6'($urandom());
        #1;
        chk("exec_alu_a", alu_a, ea);
        chk("exec_alu_b", alu_b, eb);
        chk("exec_alu_sel", alu_sel, es);
        chk("exec_req_ready", req_ready, 0);
        chk("exec_rsp_valid", rsp_valid, 0);
        chk("exec_busy", busy, 1);

        @(posedge clk); #1;
        m_dres = r[3:0]; m_dflg = r[6:4];
        chk("resp_rsp_valid", rsp_valid, oh);
        chk("resp_rsp_result", rsp_result, r[3:0]);
        chk("resp_rsp_flags", rsp_flags, r[6:4]);
        chk("resp_disp_result", disp_result, r[3:0]);
        chk("resp_disp_flags", disp_flags, r[6:4]);
        chk("resp_alu_a_hold", alu_a, ea);
        chk("resp_req_ready", req_ready, 0);
        if (abort) begin
            do_reset();
            return;
        end
        for (int i = 0; i < bp; i++) begin
            rsp_ready = ~oh;
            @(posedge clk); #1;
            chk("bp_rsp_valid", rsp_valid, oh);
            chk("bp_rsp_result", rsp_result, r[3:0]);
            chk("bp_rsp_flags", rsp_flags, r[6:4]);
            chk("bp_busy", busy, 1);
            chk("bp_req_ready", req_ready, 0);
        end
        rsp_ready = oh;
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        m_count++;
        chk("done_busy", busy, 0);
        chk("done_rsp_valid", rsp_valid, 0);
        chk("done_op_count", op_count, (m_count > 255) ? 255 : m_count);
        chk("done_op_count_sat", op_count_s, (m_count > 3) ? 3 : m_count);
        chk("done_disp_result", disp_result, m_dres);
        chk("done_disp_flags", disp_flags, m_dflg);
    endtask

    task automatic idle_hold(input int n);
        req_valid = 2'b00;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk("hold_busy", busy, 0);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_disp_result", disp_result, m_dres);
            chk("hold_disp_flags", disp_flags, m_dflg);
            chk("hold_alu_a", alu_a, m_a);
            chk("hold_alu_b", alu_b, m_b);
            chk("hold_alu_sel", alu_sel, m_s);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req_valid = '0; rsp_ready = '0;
        req_a = '0; req_b = '0; req_sel = '0;
        @(posedge clk); #1;
        do_reset();

        // Single request from requester 0 with a fixed ALU response
        use_fixed = 1'b1; fixed_res = 4'h8; fixed_flg = 3'b000;
        run_op(2'b01, 4'h5, 4'h3, 3'b010, 4'h0, 4'h0, 3'b000, 0, 1'b0);
        idle_hold(2);

        // Both requesters held valid after reset: grants alternate 0,1,0,...
        // and the CNT_W=2 instance saturates at 3
        do_reset();
        use_fixed = 1'b0;
        for (int i = 0; i < 6; i++) begin
            run_op(2'b11, 4'($urandom()), 4'($urandom()), 3'($urandom()),
                   4'($urandom()), 4'($urandom()), 3'($urandom()), 0, 1'b0);
        end

        // Response backpressure
        run_op(2'b10, 4'h9, 4'h4, 3'd3, 4'hC, 4'h7, 3'd2, 5, 1'b0);

        // Zero flag, then carry plus negative; displays hold while idle
        use_fixed = 1'b1; fixed_res = 4'h0; fixed_flg = 3'b001;
        run_op(2'b01, 4'h1, 4'h1, 3'd3, 4'h0, 4'h0, 3'd0, 1, 1'b0);
        fixed_res = 4'hF; fixed_flg = 3'b110;
        run_op(2'b10, 4'h0, 4'h0, 3'd0, 4'h7, 4'h8, 3'd2, 0, 1'b0);
        idle_hold(4);

        // Reset during the response phase, then a tie goes to requester 0
        use_fixed = 1'b0;
        run_op(2'b10, 4'h2, 4'h2, 3'd0, 4'hA, 4'h5, 3'd1, 0, 1'b1);
        run_op(2'b11, 4'h6, 4'h3, 3'd2, 4'hB, 4'h1, 3'd4, 0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 20; i++) begin
            run_op(2'($urandom_range(1, 3)), 4'($urandom()), 4'($urandom()), 3'($urandom()),
                   4'($urandom()), 4'($urandom()), 3'($urandom()),
                   int'($urandom_range(0, 3)), 1'b0);
        end
        idle_hold(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
